// File: rtl/fmul_share_arbiter_pkg.sv
// Shared types and constants for the float64 multiplier sharing arbiter.
package fmul_arb_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_e;

  // Result substituted when the core never reports done.
  localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;

endpackage

// File: rtl/fmul_share_arbiter_if.sv
// ap_ctrl_hs link between the arbiter (master) and the float64_mul core (slave).
interface fmul_share_arbiter_if;

  logic        mul_ap_start;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_ap_ready;
  logic        mul_ap_done;
  logic [63:0] mul_ap_return;

  modport master (
    output mul_ap_start, mul_a, mul_b,
    input  mul_ap_ready, mul_ap_done, mul_ap_return
  );

  modport slave (
    input  mul_ap_start, mul_a, mul_b,
    output mul_ap_ready, mul_ap_done, mul_ap_return
  );

endinterface

// File: rtl/fmul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant_i, else
// the lowest requester at or below it (wrap-around).
module rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   last_grant_i,
  output logic [GW-1:0]   grant_o,
  output logic            any_o
);

  logic          hi_found;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] lo_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so the lowest matching index in each half wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (GW'(i) > last_grant_i) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end else begin
          lo_idx = GW'(i);
        end
      end
    end
    grant_o = hi_found ? hi_idx : lo_idx;
    any_o   = |req_i;
  end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one float64_mul ap_ctrl_hs core among NREQ requesters, round-robin.
// Optional WAIT-state watchdog enabled by defining FMUL_ARB_TIMEOUT_EN.
module fmul_share_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int GW          = 3,
  parameter int CNTW        = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [63:0]          resp_data,
  output logic                 resp_timeout,
  fmul_share_arbiter_if.master mul,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);

  state_e          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [63:0]     mul_a_q, mul_a_d;
  logic [63:0]     mul_b_q, mul_b_d;
  logic [63:0]     result_q, result_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic [GW-1:0]   pick;
  logic            any_req;
  logic [63:0]     sel_a, sel_b;
  logic [NREQ-1:0] grant_oh;
  logic            resp_ack;

`ifdef FMUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
`endif

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick),
    .any_o        (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == GW'(i)) begin
        sel_a = req_a[i*64 +: 64];
        sel_b = req_b[i*64 +: 64];
      end
    end
  end

  assign grant_oh = NREQ'(1) << grant_q;
  assign resp_ack = (state_q == S_RESP) && |(resp_ready & grant_oh);

  always_comb begin
    // NOTE: every _d starts from its held value so no branch below can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    result_d     = result_q;
    op_count_d   = op_count_q;
`ifdef FMUL_ARB_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          mul_a_d = sel_a;
          mul_b_d = sel_b;
`ifdef FMUL_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul.mul_ap_ready) begin
          if (mul.mul_ap_done) begin
            result_d = mul.mul_ap_return;
            state_d  = S_RESP;
          end else begin
`ifdef FMUL_ARB_TIMEOUT_EN
            tcnt_d = '0;
`endif
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mul.mul_ap_done) begin
          result_d = mul.mul_ap_return;
          state_d  = S_RESP;
        end
`ifdef FMUL_ARB_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          result_d  = FP64_QNAN;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (resp_ack) begin
          last_grant_d = grant_q;
          if (op_count_q != '1) op_count_d = op_count_q + CNTW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NREQ - 1);
      grant_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      result_q     <= '0;
      op_count_q   <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      result_q     <= result_d;
      op_count_q   <= op_count_d;
`ifdef FMUL_ARB_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign req_ready        = (state_q == S_IDLE && any_req) ? (NREQ'(1) << pick) : '0;
  assign resp_valid       = (state_q == S_RESP) ? grant_oh : '0;
  assign resp_data        = result_q;
  assign busy             = (state_q != S_IDLE);
  assign op_count         = op_count_q;
  assign mul.mul_ap_start = (state_q == S_ISSUE);
  assign mul.mul_a        = mul_a_q;
  assign mul.mul_b        = mul_b_q;

`ifdef FMUL_ARB_TIMEOUT_EN
  assign resp_timeout = (state_q == S_RESP) && timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule
